l2_mesi_cache_ctrl: RTL and testbench
=====================================

Name: l2_mesi_cache_ctrl

Overview:
- Parametrised N-way set-associative L2 tag/state controller. Implements the MESI protocol, true-LRU replacement and shared-bus / snoop signalling.
- Consumes one trace command at a time from the trace driver.
- Emits the resulting bus operation, snoop response, writeback and hit/miss statistics.
- Tags and state only; no data storage.

Parameters:
- WAYS, 8, associativity (power of 2, ≥2)
- INDEX_BITS, 14, set-index width; SETS = 2^INDEX_BITS
- TAG_BITS, 12, tag width
- OFFSET_BITS, 6, line-offset width; ADDR_BITS = TAG_BITS+INDEX_BITS+OFFSET_BITS
- CNT_BITS, 32, statistics counter width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept
- cmd  input  4  0 rd, 1 wr, 2 ifetch, 3 snoop-inval, 4 snoop-rd, 5 snoop-wr, 6 snoop-RWIM, 8 clear
- addr  input  ADDR_BITS  byte address
- snoop_in  input  2  other caches' result for our own bus read (0 NOHIT, 1 HIT, 2 HITM); sampled with cmd
- resp_valid  output  1  one-cycle response strobe
- hit  output  1  lookup hit
- resp_state  output  2  final MESI state of the touched line (I0 S1 E2 M3)
- bus_op  output  3  0 NONE, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
- bus_addr  output  ADDR_BITS  line address for bus_op (offset zeroed)
- snoop_result  output  2  our response to a snoop (0 NOHIT, 1 HIT, 2 HITM)
- wb_valid  output  1  dirty victim evicted
- wb_addr  output  ADDR_BITS  victim line address
- hit_cnt, miss_cnt  output  CNT_BITS  CPU-command (0/1/2) hits/misses; saturate at all-ones

Behaviour:
- FSM states: INIT, IDLE, LOOKUP, RESP.
- Reset (async): FSM→INIT, set pointer=0. All outputs 0 except bus_op=NONE; counters 0.
- INIT: one set per cycle. All ways→I; ages: way w = w. After set SETS-1 → IDLE. cmd_ready=0 throughout.
- cmd_ready=1 only in IDLE. Handshake: cmd_valid&&cmd_ready captures cmd, addr, snoop_in. Then LOOKUP (1 cycle), then RESP. resp_valid=1 in RESP only, i.e. 2 cycles after accept. Back to IDLE next cycle.
- Outputs are registered. They hold their values until the next RESP.
- Hit: any way with state≠I and tag match. At most one way may match.
- Victim choice on a miss: lowest-index way in I. Otherwise the way with age WAYS-1.
- LRU update: on a CPU-command touch (hit or fill), ways with age < touched age increment; touched way→0. Snoops never alter ages.
- Read/ifetch (0/2):
  - Hit: bus NONE, state unchanged.
  - Miss: allocate victim; if victim is M → wb_valid=1, wb_addr=victim line. bus READ. New state E if snoop_in=NOHIT, else S.
- Write (1):
  - M hit: bus NONE.
  - E hit: →M, bus NONE.
  - S hit: →M, bus INVALIDATE.
  - Miss: allocate (with writeback rule as above), bus RWIM, →M.
- Snoop-rd (4):
  - M: HITM, bus WRITE, →S.
  - E: HIT, →S.
  - S: HIT.
  - Miss: NOHIT.
- Snoop-wr (5): no change, NOHIT.
- Snoop-RWIM (6):
  - M: HITM, bus WRITE, →I.
  - E/S: HIT, →I.
  - Miss: NOHIT.
- Snoop-inval (3):
  - S: HIT, →I.
  - Others: no change, NOHIT.
- Snoop commands never set wb_valid. snoop_result=NOHIT for CPU commands.
- Clear (8): FSM→INIT sweep (SETS cycles). resp_valid pulses once, on the first INIT cycle, with hit=0, bus NONE. Counters are not cleared.
- Unused cmd values: resp_valid with hit=0, bus NONE, no state change.
- Counters increment in RESP for commands 0/1/2 only.
- rst_n low mid-operation: in-flight command is dropped, no response, INIT restarts.

Test Plan:
- Bench parameters WAYS=4, INDEX_BITS=2, TAG_BITS=4, OFFSET_BITS=2.
- Reset, then hold cmd_valid → cmd_ready low for 4 cycles then high; all outputs 0.
- rd 0x10 with snoop_in=0 → miss, bus READ 0x10, resp_state E; rd 0x11 → hit, bus NONE, hit_cnt=1, miss_cnt=1.
- wr 0x10 (E) → M, bus NONE; snoop-rd 0x10 → HITM, bus WRITE, resp_state S; wr 0x10 → bus INVALIDATE, M.
- Set 0 filled with writes to tags 0–3 (addresses 0x00,0x10,0x20,0x30, all M); rd 0x00; wr 0x40 → victim tag1, wb_valid=1, wb_addr=0x10, bus RWIM.
- rd 0x24 with snoop_in=1 → S; snoop-RWIM 0x24 → HIT, →I; subsequent rd 0x24 → miss.
- Accept rd, assert rst_n low in LOOKUP → no resp_valid; after release, 4 INIT cycles, then rd 0x10 misses.

Source files
------------

// File: rtl/l2_mesi_cache_ctrl_if.sv
// rtl/l2_mesi_cache_ctrl_if.sv - trace-command / response bundle for the L2 MESI controller
interface l2_mesi_cache_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int CNT_BITS  = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd;
  logic [ADDR_BITS-1:0] addr;
  logic [1:0]           snoop_in;
  logic                 resp_valid;
  logic                 hit;
  logic [1:0]           resp_state;
  logic [2:0]           bus_op;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [1:0]           snoop_result;
  logic                 wb_valid;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [CNT_BITS-1:0]  hit_cnt;
  logic [CNT_BITS-1:0]  miss_cnt;

  modport master (
    output cmd_valid, cmd, addr, snoop_in,
    input  cmd_ready, resp_valid, hit, resp_state, bus_op, bus_addr,
           snoop_result, wb_valid, wb_addr, hit_cnt, miss_cnt
  );

  modport slave (
    input  cmd_valid, cmd, addr, snoop_in,
    output cmd_ready, resp_valid, hit, resp_state, bus_op, bus_addr,
           snoop_result, wb_valid, wb_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/l2_mesi_cache_ctrl.sv
// rtl/l2_mesi_cache_ctrl.sv - N-way L2 tag/state controller with MESI, true-LRU and snoop handling
module l2_mesi_cache_ctrl #(
  parameter int WAYS        = 8,
  parameter int INDEX_BITS  = 14,
  parameter int TAG_BITS    = 12,
  parameter int OFFSET_BITS = 6,
  parameter int CNT_BITS    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_mesi_cache_ctrl_if.slave bus
);
  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int SETS      = 1 << INDEX_BITS;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFFSET_BITS) - 64'd1);

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2,
                         BUS_INVAL = 3'd3, BUS_RWIM = 3'd4;
  localparam logic [1:0] SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2;
  localparam logic [3:0] CMD_RD = 4'd0, CMD_WR = 4'd1, CMD_IF = 4'd2, CMD_SINV = 4'd3,
                         CMD_SRD = 4'd4, CMD_SWR = 4'd5, CMD_SRWIM = 4'd6, CMD_CLR = 4'd8;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_RESP} fsm_t;

  fsm_t                  r_state, w_next;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [3:0]            r_cmd;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [1:0]            r_snoop;

  logic [TAG_BITS-1:0]   r_tag  [SETS][WAYS];
  logic [1:0]            r_mesi [SETS][WAYS];
  logic [WAY_BITS-1:0]   r_age  [SETS][WAYS];

  logic [ADDR_BITS-1:0]  w_line_addr, w_victim_line;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic                  w_hit, w_inv_found;
  logic [WAY_BITS-1:0]   w_hit_way, w_inv_way, w_lru_way, w_way, w_touch_age;
  logic [1:0]            w_cur_st, w_new_st, w_snp;
  logic [2:0]            w_bus;
  logic                  w_wb, w_touch, w_fill, w_cpu, w_known, w_resp_hit, w_upd;

  assign w_line_addr = r_addr & ~OFF_MASK;
  assign w_tag       = w_line_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_index     = w_line_addr[OFFSET_BITS +: INDEX_BITS];

  // Downward scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[w_index][w] != ST_I && r_tag[w_index][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (r_mesi[w_index][w] == ST_I) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_BITS'(w);
      end
      if (r_age[w_index][w] == WAY_BITS'(WAYS - 1)) w_lru_way = WAY_BITS'(w);
    end
  end

  assign w_way         = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_lru_way);
  assign w_cur_st      = w_hit ? r_mesi[w_index][w_hit_way] : ST_I;
  assign w_touch_age   = r_age[w_index][w_way];
  assign w_victim_line = {r_tag[w_index][w_way], w_index, {OFFSET_BITS{1'b0}}};
  assign w_upd         = w_known && (w_hit || w_fill);

  always_comb begin
    w_new_st   = w_cur_st;
    w_bus      = BUS_NONE;
    w_snp      = SN_NOHIT;
    w_wb       = 1'b0;
    w_touch    = 1'b0;
    w_fill     = 1'b0;
    w_cpu      = 1'b0;
    w_known    = 1'b1;
    w_resp_hit = w_hit;
    case (r_cmd)
      CMD_RD, CMD_IF: begin
        w_cpu   = 1'b1;
        w_touch = 1'b1;
        if (!w_hit) begin
          w_fill   = 1'b1;
          w_wb     = (r_mesi[w_index][w_way] == ST_M);
          w_bus    = BUS_READ;
          w_new_st = (r_snoop == SN_NOHIT) ? ST_E : ST_S;
        end
      end
      CMD_WR: begin
        w_cpu    = 1'b1;
        w_touch  = 1'b1;
        w_new_st = ST_M;
        if (!w_hit) begin
          w_fill = 1'b1;
          w_wb   = (r_mesi[w_index][w_way] == ST_M);
          w_bus  = BUS_RWIM;
        end else if (w_cur_st == ST_S) begin
          w_bus = BUS_INVAL;
        end
      end
      CMD_SINV: begin
        if (w_hit && w_cur_st == ST_S) begin
          w_snp    = SN_HIT;
          w_new_st = ST_I;
        end
      end
      CMD_SRD: begin
        if (w_hit) begin
          w_snp    = (w_cur_st == ST_M) ? SN_HITM : SN_HIT;
          w_bus    = (w_cur_st == ST_M) ? BUS_WRITE : BUS_NONE;
          w_new_st = ST_S;
        end
      end
      CMD_SWR: begin
      end
      CMD_SRWIM: begin
        if (w_hit) begin
          w_snp    = (w_cur_st == ST_M) ? SN_HITM : SN_HIT;
          w_bus    = (w_cur_st == ST_M) ? BUS_WRITE : BUS_NONE;
          w_new_st = ST_I;
        end
      end
      default: begin
        w_known    = 1'b0;
        w_resp_hit = 1'b0;
        w_new_st   = ST_I;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   if (r_ptr == '1) w_next = S_IDLE;
      S_IDLE:   if (bus.cmd_valid) w_next = S_LOOKUP;
      S_LOOKUP: w_next = (r_cmd == CMD_CLR) ? S_INIT : S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == S_IDLE);

  // Tag/state/age arrays carry no reset: the INIT sweep establishes them.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        r_mesi[r_ptr][w] <= ST_I;
        r_age[r_ptr][w]  <= WAY_BITS'(w);
      end
    end else if (r_state == S_LOOKUP) begin
      if (w_upd)  r_mesi[w_index][w_way] <= w_new_st;
      if (w_fill) r_tag[w_index][w_way]  <= w_tag;
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == w_way)                 r_age[w_index][w] <= '0;
          else if (r_age[w_index][w] < w_touch_age)  r_age[w_index][w] <= r_age[w_index][w] + WAY_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_INIT;
      r_ptr            <= '0;
      r_cmd            <= '0;
      r_addr           <= '0;
      r_snoop          <= '0;
      bus.resp_valid   <= 1'b0;
      bus.hit          <= 1'b0;
      bus.resp_state   <= ST_I;
      bus.bus_op       <= BUS_NONE;
      bus.bus_addr     <= '0;
      bus.snoop_result <= SN_NOHIT;
      bus.wb_valid     <= 1'b0;
      bus.wb_addr      <= '0;
      bus.hit_cnt      <= '0;
      bus.miss_cnt     <= '0;
    end else begin
      r_state        <= w_next;
      bus.resp_valid <= (r_state == S_LOOKUP);
      if (r_state == S_INIT) r_ptr <= r_ptr + INDEX_BITS'(1);
      if (r_state == S_IDLE && bus.cmd_valid) begin
        r_cmd   <= bus.cmd;
        r_addr  <= bus.addr;
        r_snoop <= bus.snoop_in;
      end
      if (r_state == S_LOOKUP) begin
        bus.hit          <= w_resp_hit;
        bus.resp_state   <= w_new_st;
        bus.bus_op       <= w_bus;
        bus.bus_addr     <= w_line_addr;
        bus.snoop_result <= w_snp;
        bus.wb_valid     <= w_wb;
        bus.wb_addr      <= w_wb ? w_victim_line : '0;
        if (w_cpu && w_hit && !(&bus.hit_cnt))   bus.hit_cnt  <= bus.hit_cnt + CNT_BITS'(1);
        if (w_cpu && !w_hit && !(&bus.miss_cnt)) bus.miss_cnt <= bus.miss_cnt + CNT_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_l2_mesi_cache_ctrl.sv
// tb/tb_l2_mesi_cache_ctrl.sv - scoreboard bench for l2_mesi_cache_ctrl (4-way, 4 sets, 8-bit addresses)
module tb_l2_mesi_cache_ctrl;
  localparam int WAYS = 4, INDEX_BITS = 2, TAG_BITS = 4, OFFSET_BITS = 2, CNT_BITS = 32;
  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;

  localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;
  localparam logic [2:0] NONE = 3'd0, READ = 3'd1, WRITE = 3'd2, INVAL = 3'd3, RWIM = 3'd4;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [1:0] st;
    logic [2:0] bus;
    logic [7:0] baddr;
    logic [1:0] snp;
    logic       wb;
    logic [7:0] waddr;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  resp_t exp_q[$];
  resp_t obs_q[$];

  l2_mesi_cache_ctrl_if #(.ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)) bif();

  l2_mesi_cache_ctrl #(
    .WAYS(WAYS), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS),
    .OFFSET_BITS(OFFSET_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif)
  );

  always #5 clk = ~clk;

  function automatic resp_t mk(input logic h, input logic [1:0] st, input logic [2:0] b,
                               input logic [7:0] ba, input logic [1:0] sn, input logic wb,
                               input logic [7:0] wa);
    resp_t r;
    r.hit = h; r.st = st; r.bus = b; r.baddr = ba; r.snp = sn; r.wb = wb; r.waddr = wa;
    return r;
  endfunction

  // Address fields are only meaningful when a bus op / writeback is expected.
  function automatic resp_t mask(input resp_t r, input resp_t e);
    resp_t m;
    m = r;
    if (e.bus == NONE) m.baddr = '0;
    if (!e.wb) m.waddr = '0;
    return m;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [1:0] s);
    int n;
    resp_t o;
    bif.cmd = c; bif.addr = a; bif.snoop_in = s; bif.cmd_valid = 1'b1;
    n = 0;
    while (bif.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (bif.cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout cmd=%0d ready=%b required=1", c, bif.cmd_ready);
      bif.cmd_valid = 1'b0; o = 'x; obs_q.push_back(o);
      return;
    end
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    n = 0;
    while (bif.resp_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    if (bif.resp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL resp_timeout cmd=%0d addr=%h resp_valid=%b required=1", c, a, bif.resp_valid);
      o = 'x; obs_q.push_back(o);
      return;
    end
    o = mk(bif.hit, bif.resp_state, bif.bus_op, bif.bus_addr, bif.snoop_result, bif.wb_valid, bif.wb_addr);
    obs_q.push_back(o);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.cmd_valid = 1'b1; bif.cmd = 4'd0; bif.addr = 8'h10; bif.snoop_in = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.resp_valid, bif.hit, bif.resp_state, bif.bus_op, bif.bus_addr, bif.snoop_result,
         bif.wb_valid, bif.wb_addr, bif.hit_cnt, bif.miss_cnt} !== 90'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {bif.resp_valid, bif.hit, bif.resp_state,
               bif.bus_op, bif.bus_addr, bif.snoop_result, bif.wb_valid, bif.wb_addr, bif.hit_cnt, bif.miss_cnt});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.cmd_ready !== 1'b0) begin failures++; $display("FAIL init_ready cycle=%0d got=%b required=0", i, bif.cmd_ready); end
      @(negedge clk);
    end
    checks++;
    if (bif.cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b required=1", bif.cmd_ready); end
    bif.cmd_valid = 1'b0;
  endtask

  task automatic test_read_hit();
    resp_t e, o;
    int k;
    exp_q.push_back(mk(1'b0, E, READ, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h10, 2'd0);
    exp_q.push_back(mk(1'b1, E, NONE, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h11, 2'd0);
    checks++;
    if (bif.resp_valid !== 1'b0) begin failures++; $display("FAIL resp_pulse_width got=%b required=0", bif.resp_valid); end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL read_hit resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.hit_cnt !== 32'd1 || bif.miss_cnt !== 32'd1) begin
      failures++; $display("FAIL read_hit_counters got=%0d/%0d required=1/1", bif.hit_cnt, bif.miss_cnt);
    end
  endtask

  task automatic test_write_snoop();
    resp_t e, o;
    int k;
    exp_q.push_back(mk(1'b1, M, NONE,  8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h10, 2'd0);
    exp_q.push_back(mk(1'b1, S, WRITE, 8'h10, HITM,  1'b0, 8'h00)); issue(4'd4, 8'h10, 2'd0);
    exp_q.push_back(mk(1'b1, M, INVAL, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h10, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL write_snoop resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.hit_cnt !== 32'd3 || bif.miss_cnt !== 32'd1) begin
      failures++; $display("FAIL write_snoop_counters got=%0d/%0d required=3/1", bif.hit_cnt, bif.miss_cnt);
    end
  endtask

  task automatic test_eviction();
    resp_t e, o;
    int k;
    exp_q.push_back(mk(1'b0, M, RWIM, 8'h00, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h00, 2'd0);
    exp_q.push_back(mk(1'b1, M, NONE, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h10, 2'd0);
    exp_q.push_back(mk(1'b0, M, RWIM, 8'h20, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h20, 2'd0);
    exp_q.push_back(mk(1'b0, M, RWIM, 8'h30, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h30, 2'd0);
    exp_q.push_back(mk(1'b1, M, NONE, 8'h00, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h00, 2'd0);
    exp_q.push_back(mk(1'b0, M, RWIM, 8'h40, NOHIT, 1'b1, 8'h10)); issue(4'd1, 8'h40, 2'd0);
    exp_q.push_back(mk(1'b0, E, READ, 8'h10, NOHIT, 1'b1, 8'h20)); issue(4'd2, 8'h10, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL eviction resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.hit_cnt !== 32'd5 || bif.miss_cnt !== 32'd6) begin
      failures++; $display("FAIL eviction_counters got=%0d/%0d required=5/6", bif.hit_cnt, bif.miss_cnt);
    end
  endtask

  task automatic test_shared_snoop();
    resp_t e, o;
    int k;
    exp_q.push_back(mk(1'b0, S, READ, 8'h24, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h24, 2'd1);
    exp_q.push_back(mk(1'b1, I, NONE, 8'h24, HIT,   1'b0, 8'h00)); issue(4'd6, 8'h24, 2'd0);
    exp_q.push_back(mk(1'b0, S, READ, 8'h24, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h24, 2'd2);
    exp_q.push_back(mk(1'b0, I, NONE, 8'h74, NOHIT, 1'b0, 8'h00)); issue(4'd4, 8'h74, 2'd0);
    exp_q.push_back(mk(1'b1, I, NONE, 8'h24, HIT,   1'b0, 8'h00)); issue(4'd3, 8'h24, 2'd0);
    exp_q.push_back(mk(1'b0, E, READ, 8'h34, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h34, 2'd0);
    exp_q.push_back(mk(1'b1, S, NONE, 8'h34, HIT,   1'b0, 8'h00)); issue(4'd4, 8'h34, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL shared_snoop resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.hit_cnt !== 32'd5 || bif.miss_cnt !== 32'd9) begin
      failures++; $display("FAIL shared_snoop_counters got=%0d/%0d required=5/9", bif.hit_cnt, bif.miss_cnt);
    end
  endtask

  task automatic test_clear();
    resp_t e, o;
    int k;
    exp_q.push_back(mk(1'b0, I, NONE, 8'h00, NOHIT, 1'b0, 8'h00)); issue(4'd8, 8'h00, 2'd0);
    checks++;
    if (bif.cmd_ready !== 1'b0) begin failures++; $display("FAIL clear_sweep_ready got=%b required=0", bif.cmd_ready); end
    exp_q.push_back(mk(1'b0, E, READ, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h10, 2'd0);
    exp_q.push_back(mk(1'b0, M, RWIM, 8'h40, NOHIT, 1'b0, 8'h00)); issue(4'd1, 8'h40, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL clear resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.hit_cnt !== 32'd5 || bif.miss_cnt !== 32'd11) begin
      failures++; $display("FAIL clear_counters got=%0d/%0d required=5/11", bif.hit_cnt, bif.miss_cnt);
    end
  endtask

  task automatic test_midop_reset();
    resp_t e, o;
    int k, n;
    logic seen;
    bif.cmd = 4'd0; bif.addr = 8'h10; bif.snoop_in = 2'd0; bif.cmd_valid = 1'b1;
    n = 0;
    while (bif.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bif.cmd_ready !== 1'b1) begin failures++; $display("FAIL midop_accept got=%b required=1", bif.cmd_ready); end
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    seen = bif.resp_valid;
    rst_n = 1'b0;
    @(negedge clk);
    seen = seen | bif.resp_valid;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.cmd_ready !== 1'b0) begin failures++; $display("FAIL midop_init_ready cycle=%0d got=%b required=0", i, bif.cmd_ready); end
      seen = seen | bif.resp_valid;
      @(negedge clk);
    end
    checks++;
    if (bif.cmd_ready !== 1'b1) begin failures++; $display("FAIL midop_idle_ready got=%b required=1", bif.cmd_ready); end
    checks++;
    if ((seen | bif.resp_valid) !== 1'b0) begin failures++; $display("FAIL midop_dropped_resp got=1 required=0"); end
    checks++;
    if (bif.hit_cnt !== 32'd0 || bif.miss_cnt !== 32'd0) begin
      failures++; $display("FAIL midop_counters got=%0d/%0d required=0/0", bif.hit_cnt, bif.miss_cnt);
    end
    exp_q.push_back(mk(1'b0, E, READ, 8'h10, NOHIT, 1'b0, 8'h00)); issue(4'd0, 8'h10, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; k++;
      if (mask(o, e) !== mask(e, e)) begin failures++; $display("FAIL midop resp%0d got=%h required=%h", k, mask(o, e), mask(e, e)); end
    end
    checks++;
    if (bif.miss_cnt !== 32'd1) begin failures++; $display("FAIL midop_miss_cnt got=%0d required=1", bif.miss_cnt); end
  endtask

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd = 4'd0; bif.addr = '0; bif.snoop_in = 2'd0;
    @(negedge clk);
    test_reset();
    test_read_hit();
    test_write_snoop();
    test_eviction();
    test_shared_snoop();
    test_clear();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
